// File: rtl/delivery_pkg.sv
// delivery_pkg: state, display-code and after-uturn encodings
// shared by the delivery sequencer and its output decoder.
package delivery_pkg;

  typedef enum logic [8:0] {
    S_READY   = 9'h001,
    S_NOCOLOR = 9'h002,
    S_SEND    = 9'h004,
    S_MATCH   = 9'h008,
    S_EOT     = 9'h010,
    S_UTURN   = 9'h020,
    S_RETURN  = 9'h040,
    S_REVERSE = 9'h080,
    S_FAULT   = 9'h100
  } state_t;

  typedef enum logic [1:0] {
    AU_SEND    = 2'd0,
    AU_RETURN  = 2'd1,
    AU_REVERSE = 2'd2
  } after_t;

  localparam logic [3:0] CODE_READY   = 4'd0;
  localparam logic [3:0] CODE_SEND    = 4'd1;
  localparam logic [3:0] CODE_ARRIVED = 4'd2;
  localparam logic [3:0] CODE_GIVEUP  = 4'd3;
  localparam logic [3:0] CODE_UTURN   = 4'd4;
  localparam logic [3:0] CODE_RETURN  = 4'd5;
  localparam logic [3:0] CODE_REVERSE = 4'd6;
  localparam logic [3:0] CODE_NOCOLOR = 4'd7;
  localparam logic [3:0] CODE_SEARCH  = 4'd8;
  localparam logic [3:0] CODE_FAULT   = 4'd15;

  typedef struct packed {
    logic       tracking;
    logic       uturn;
    logic       brake;
    logic       reverse;
    logic       buzz;
    logic       object_led;
    logic       station_led;
    logic       fault;
    logic [3:0] code;
  } outs_t;

  localparam outs_t OUT_RST = outs_t'(12'b0000_0100_0000);

  function automatic outs_t outs_of(state_t s, logic again);
    outs_t o;
    o = '0;
    case (s)
      S_READY: o.object_led = 1'b1;
      S_NOCOLOR: begin
        o.buzz       = 1'b1;
        o.object_led = 1'b1;
        o.code       = CODE_NOCOLOR;
      end
      S_SEND: begin
        o.tracking    = 1'b1;
        o.station_led = 1'b1;
        o.code        = again ? CODE_SEARCH : CODE_SEND;
      end
      S_MATCH: begin
        o.brake = 1'b1;
        o.buzz  = 1'b1;
        o.code  = CODE_ARRIVED;
      end
      S_EOT: begin
        o.brake = 1'b1;
        o.buzz  = 1'b1;
        o.code  = CODE_GIVEUP;
      end
      S_UTURN: begin
        o.uturn = 1'b1;
        o.code  = CODE_UTURN;
      end
      S_RETURN: begin
        o.tracking = 1'b1;
        o.code     = CODE_RETURN;
      end
      S_REVERSE: begin
        o.reverse = 1'b1;
        o.code    = CODE_REVERSE;
      end
      S_FAULT: begin
        o.buzz  = 1'b1;
        o.fault = 1'b1;
        o.code  = CODE_FAULT;
      end
      default: o.object_led = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/delivery_ctrl_if.sv
// delivery_ctrl_if: actuator enables and level feedbacks between
// the sequencer and the Trackuturn/Buzzer blocks.
interface delivery_ctrl_if;
  logic end_of_track;
  logic uturn_finished;
  logic brake_finished;
  logic reverse_finished;
  logic buzz_finished;
  logic en_tracking;
  logic en_uturn;
  logic en_brake;
  logic en_reverse;
  logic en_buzz;

  modport master (
    input  end_of_track, uturn_finished, brake_finished,
    input  reverse_finished, buzz_finished,
    output en_tracking, en_uturn, en_brake, en_reverse, en_buzz
  );

  modport slave (
    output end_of_track, uturn_finished, brake_finished,
    output reverse_finished, buzz_finished,
    input  en_tracking, en_uturn, en_brake, en_reverse, en_buzz
  );
endinterface

// File: rtl/hall_debounce.sv
// hall_debounce: synchronises the raw hall level, debounces it and
// emits a one-cycle press on each accepted high-to-low transition.
module hall_debounce #(
  parameter int DEBOUNCE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic hall,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // Idle level is high: no magnet under the sensor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= hall;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= s2;
        press <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/delivery_ctrl.sv
// delivery_ctrl: delivery sequencer with debounced go button,
// multi-pass station search and per-state watchdog.
module delivery_ctrl
  import delivery_pkg::*;
#(
  parameter int COLOR_W    = 2,
  parameter int DEBOUNCE   = 50000,
  parameter int MAX_PASSES = 2,
  parameter int TIMEOUT    = 500000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hall,
  input  logic [COLOR_W-1:0] object_color,
  input  logic [COLOR_W-1:0] station_color,
  delivery_ctrl_if.master    cart,
  output logic [3:0]         state_code,
  output logic [COLOR_W-1:0] color_code,
  output logic               object_led,
  output logic               station_led,
  output logic               fault
);
  localparam int PW = $clog2(MAX_PASSES + 1);
  localparam int WW = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  after_t             after_q, after_d;
  logic [PW-1:0]      pass_q, pass_d, pass_inc;
  logic [WW-1:0]      wd_q, wd_d;
  logic [COLOR_W-1:0] color_q, color_d;
  outs_t              out_q, out_d;
  logic               press;
  logic               watched;

  hall_debounce #(.DEBOUNCE(DEBOUNCE)) u_hall (
    .clk   (clk),
    .rst   (rst),
    .hall  (hall),
    .press (press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_READY;
      after_q <= AU_SEND;
      pass_q  <= '0;
      wd_q    <= '0;
      color_q <= '0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      pass_q  <= pass_d;
      wd_q    <= wd_d;
      color_q <= color_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    after_d  = after_q;
    pass_d   = pass_q;
    color_d  = color_q;
    pass_inc = pass_q + PW'(1);
    watched  = state_q inside {S_SEND, S_UTURN, S_RETURN, S_REVERSE};
    if (watched && wd_q == WW'(TIMEOUT - 1)) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_READY:
          if (press) begin
            if (object_color == '0) begin
              state_d = S_NOCOLOR;
            end else begin
              state_d = S_SEND;
              color_d = object_color;
              pass_d  = '0;
            end
          end
        S_NOCOLOR:
          if (cart.buzz_finished) state_d = S_READY;
        S_SEND:
          // A station match wins over end-of-track in the same cycle.
          if (color_q != '0 && station_color == color_q) begin
            state_d = S_MATCH;
          end else if (cart.end_of_track) begin
            pass_d = pass_inc;
            if (pass_inc < PW'(MAX_PASSES)) begin
              after_d = AU_SEND;
              state_d = S_UTURN;
            end else begin
              state_d = S_EOT;
            end
          end
        S_MATCH:
          if (press) begin
            after_d = AU_RETURN;
            state_d = S_UTURN;
          end
        S_EOT:
          if (cart.buzz_finished && cart.brake_finished) begin
            after_d = AU_RETURN;
            state_d = S_UTURN;
          end
        S_UTURN:
          if (cart.uturn_finished) begin
            case (after_q)
              AU_SEND:    state_d = S_SEND;
              AU_RETURN:  state_d = S_RETURN;
              AU_REVERSE: state_d = S_REVERSE;
              default:    state_d = S_READY;
            endcase
          end
        S_RETURN:
          if (cart.end_of_track) begin
            after_d = AU_REVERSE;
            state_d = S_UTURN;
          end
        S_REVERSE:
          if (cart.reverse_finished) state_d = S_READY;
        S_FAULT:
          if (press) state_d = S_READY;
        default: state_d = S_READY;
      endcase
    end
    if (state_d == S_READY) begin
      color_d = '0;
      pass_d  = '0;
    end
    if (state_d == S_RETURN) color_d = '0;
    if (state_d != state_q || !watched) wd_d = '0;
    else wd_d = wd_q + WW'(1);
    out_d = outs_of(state_d, pass_d != '0);
  end

  assign cart.en_tracking = out_q.tracking;
  assign cart.en_uturn    = out_q.uturn;
  assign cart.en_brake    = out_q.brake;
  assign cart.en_reverse  = out_q.reverse;
  assign cart.en_buzz     = out_q.buzz;
  assign state_code       = out_q.code;
  assign color_code       = color_q;
  assign object_led       = out_q.object_led;
  assign station_led      = out_q.station_led;
  assign fault            = out_q.fault;
endmodule

// File: tb/tb_delivery_ctrl.sv
// tb_delivery_ctrl: directed scenarios plus a randomized run
// checked against a behavioural model of the sequencer.
module tb_delivery_ctrl;
  localparam int DEB = 4;
  localparam int MP  = 2;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hall = 1'b1;
  logic [1:0] obj = 2'd0;
  logic [1:0] sta = 2'd0;
  logic [3:0] state_code;
  logic [1:0] color_code;
  logic       object_led, station_led, fault;
  int         checks = 0;
  int         failures = 0;

  delivery_ctrl_if cart();

  delivery_ctrl #(
    .COLOR_W(2), .DEBOUNCE(DEB), .MAX_PASSES(MP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .hall(hall),
    .object_color(obj), .station_color(sta),
    .cart(cart),
    .state_code(state_code), .color_code(color_code),
    .object_led(object_led), .station_led(station_led),
    .fault(fault)
  );

  always #5 clk = ~clk;

  wire [13:0] snap = {cart.en_tracking, cart.en_uturn, cart.en_brake,
                      cart.en_reverse, cart.en_buzz, object_led,
                      station_led, fault, state_code, color_code};

  // Behavioural model: spec rules per cycle, press from a hall history window.
  typedef enum {M_RDY, M_NOC, M_SND, M_MAT, M_EOT,
                M_UT, M_RET, M_REV, M_FLT} mst_t;
  mst_t       ms, ma;
  int         mpass, mwd;
  logic [1:0] mlat;
  logic       mdeb, mpress;
  logic [8:1] hist;

  function automatic void m_reset();
    ms = M_RDY; ma = M_SND; mpass = 0; mwd = 0; mlat = 2'd0;
    mdeb = 1'b1; mpress = 1'b0; hist = '1;
  endfunction

  function automatic void m_step();
    mst_t nx;
    logic diff;
    nx = ms;
    if ((ms == M_SND || ms == M_UT || ms == M_RET || ms == M_REV)
        && mwd == TO - 1) nx = M_FLT;
    else case (ms)
      M_RDY: if (mpress) begin
        if (obj == 2'd0) nx = M_NOC;
        else begin nx = M_SND; mlat = obj; mpass = 0; end
      end
      M_NOC: if (cart.buzz_finished) nx = M_RDY;
      M_SND: if (sta == mlat) nx = M_MAT;
        else if (cart.end_of_track) begin
          mpass = mpass + 1;
          if (mpass < MP) begin ma = M_SND; nx = M_UT; end
          else nx = M_EOT;
        end
      M_MAT: if (mpress) begin ma = M_RET; nx = M_UT; end
      M_EOT: if (cart.buzz_finished && cart.brake_finished) begin
        ma = M_RET; nx = M_UT;
      end
      M_UT: if (cart.uturn_finished) nx = ma;
      M_RET: if (cart.end_of_track) begin ma = M_REV; nx = M_UT; end
      M_REV: if (cart.reverse_finished) nx = M_RDY;
      M_FLT: if (mpress) nx = M_RDY;
      default: nx = M_RDY;
    endcase
    if (nx == M_RDY) begin mlat = 2'd0; mpass = 0; end
    if (nx == M_RET) mlat = 2'd0;
    mwd = (nx == ms) ? mwd + 1 : 0;
    ms = nx;
    diff = 1'b1;
    for (int i = 2; i <= DEB + 1; i++) if (hist[i] == mdeb) diff = 1'b0;
    mpress = 1'b0;
    if (diff) begin mdeb = ~mdeb; mpress = ~mdeb; end
    hist = {hist[7:1], hall};
  endfunction

  function automatic logic [7:0] m_outs();
    case (ms)
      M_RDY:   return 8'b0000_0100;
      M_NOC:   return 8'b0000_1100;
      M_SND:   return 8'b1000_0010;
      M_MAT:   return 8'b0010_1000;
      M_EOT:   return 8'b0010_1000;
      M_UT:    return 8'b0100_0000;
      M_RET:   return 8'b1000_0000;
      M_REV:   return 8'b0001_0000;
      default: return 8'b0000_1001;
    endcase
  endfunction

  function automatic logic [3:0] m_code();
    case (ms)
      M_RDY:   return 4'd0;
      M_NOC:   return 4'd7;
      M_SND:   return (mpass == 0) ? 4'd1 : 4'd8;
      M_MAT:   return 4'd2;
      M_EOT:   return 4'd3;
      M_UT:    return 4'd4;
      M_RET:   return 4'd5;
      M_REV:   return 4'd6;
      default: return 4'd15;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else m_step();
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fb(input logic e, u, b, r, z);
    cart.end_of_track = e; cart.uturn_finished = u;
    cart.brake_finished = b; cart.reverse_finished = r;
    cart.buzz_finished = z;
    tick(1);
    cart.end_of_track = 0; cart.uturn_finished = 0;
    cart.brake_finished = 0; cart.reverse_finished = 0;
    cart.buzz_finished = 0;
  endtask

  task automatic press_btn();
    hall = 1'b1; tick(DEB + 2);
    hall = 1'b0; tick(DEB + 2);
    hall = 1'b1; tick(1);
  endtask

  task automatic finish_return();
    fb(1, 0, 0, 0, 0);
    fb(0, 1, 0, 0, 0);
    fb(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    logic [13:0] e;
    e = {8'b0000_0100, 4'd0, 2'd0};
    checks++;
    if (snap !== e) begin
      failures++; $display("FAIL reset got %h want %h", snap, e);
    end
  endtask

  task automatic test_delivery();
    logic [13:0] e;
    obj = 2'd2; sta = 2'd0;
    press_btn();
    e = {8'b1000_0010, 4'd1, 2'd2}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_send got %h want %h", snap, e); end
    sta = 2'd2; tick(1); sta = 2'd0;
    e = {8'b0010_1000, 4'd2, 2'd2}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_match got %h want %h", snap, e); end
    press_btn();
    e = {8'b0100_0000, 4'd4, 2'd2}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_uturn got %h want %h", snap, e); end
    fb(0, 1, 0, 0, 0);
    e = {8'b1000_0000, 4'd5, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_return got %h want %h", snap, e); end
    fb(1, 0, 0, 0, 0);
    e = {8'b0100_0000, 4'd4, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_uturn2 got %h want %h", snap, e); end
    fb(0, 1, 0, 0, 0);
    e = {8'b0001_0000, 4'd6, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_reverse got %h want %h", snap, e); end
    fb(0, 0, 0, 1, 0);
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL dlv_ready got %h want %h", snap, e); end
  endtask

  task automatic test_nocolor();
    logic [13:0] e;
    obj = 2'd0;
    press_btn();
    e = {8'b0000_1100, 4'd7, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL nocolor got %h want %h", snap, e); end
    fb(0, 0, 0, 0, 1);
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL nocolor_ready got %h want %h", snap, e); end
  endtask

  task automatic test_passes();
    logic [13:0] e;
    logic [1:0]  o;
    o = 2'($urandom_range(1, 3));
    obj = o; sta = 2'((o % 3) + 1);
    press_btn();
    fb(1, 0, 0, 0, 0);
    e = {8'b0100_0000, 4'd4, o}; checks++;
    if (snap !== e) begin failures++; $display("FAIL pass1_uturn got %h want %h", snap, e); end
    fb(0, 1, 0, 0, 0);
    e = {8'b1000_0010, 4'd8, o}; checks++;
    if (snap !== e) begin failures++; $display("FAIL pass1_search got %h want %h", snap, e); end
    fb(1, 0, 0, 0, 0);
    e = {8'b0010_1000, 4'd3, o}; checks++;
    if (snap !== e) begin failures++; $display("FAIL giveup got %h want %h", snap, e); end
    fb(0, 0, 1, 0, 0);
    checks++;
    if (snap !== e) begin failures++; $display("FAIL giveup_hold got %h want %h", snap, e); end
    fb(0, 0, 1, 0, 1);
    e = {8'b0100_0000, 4'd4, o}; checks++;
    if (snap !== e) begin failures++; $display("FAIL giveup_uturn got %h want %h", snap, e); end
    fb(0, 1, 0, 0, 0);
    e = {8'b1000_0000, 4'd5, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL giveup_return got %h want %h", snap, e); end
    sta = 2'd0;
    finish_return();
  endtask

  task automatic test_priority();
    logic [13:0] e;
    logic [1:0]  o;
    o = 2'($urandom_range(1, 3));
    obj = o; sta = 2'd0;
    press_btn();
    fb(1, 0, 0, 0, 0);
    fb(0, 1, 0, 0, 0);
    sta = o;
    fb(1, 0, 0, 0, 0);
    sta = 2'd0;
    e = {8'b0010_1000, 4'd2, o}; checks++;
    if (snap !== e) begin failures++; $display("FAIL match_prio got %h want %h", snap, e); end
    press_btn();
    fb(0, 1, 0, 0, 0);
    finish_return();
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL prio_ready got %h want %h", snap, e); end
  endtask

  task automatic test_watchdog();
    logic [13:0] e;
    obj = 2'd1; sta = 2'd0;
    press_btn();
    fb(1, 0, 0, 0, 0);
    tick(TO - 1);
    e = {8'b0100_0000, 4'd4, 2'd1}; checks++;
    if (snap !== e) begin failures++; $display("FAIL wd_early got %h want %h", snap, e); end
    tick(1);
    e = {8'b0000_1001, 4'd15, 2'd1}; checks++;
    if (snap !== e) begin failures++; $display("FAIL wd_fault got %h want %h", snap, e); end
    press_btn();
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL wd_ready got %h want %h", snap, e); end
  endtask

  task automatic test_glitch();
    logic [13:0] e;
    obj = 2'd2;
    hall = 1'b0; tick(DEB - 1);
    hall = 1'b1; tick(DEB + 8);
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL glitch got %h want %h", snap, e); end
  endtask

  task automatic test_async_reset();
    logic [13:0] e;
    obj = 2'd3; sta = 2'd0;
    press_btn();
    sta = 2'd3; tick(1); sta = 2'd0;
    press_btn();
    fb(0, 1, 0, 0, 0);
    e = {8'b1000_0000, 4'd5, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL ar_return got %h want %h", snap, e); end
    #2 rst = 1'b0;
    #1;
    e = {8'b0000_0100, 4'd0, 2'd0}; checks++;
    if (snap !== e) begin failures++; $display("FAIL ar_reset got %h want %h", snap, e); end
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) hall = ~hall;
      if ($urandom_range(0, 19) == 0) obj = 2'($urandom_range(0, 3));
      sta = 2'($urandom_range(0, 3));
      cart.end_of_track     = ($urandom_range(0, 3) == 0);
      cart.uturn_finished   = ($urandom_range(0, 3) == 0);
      cart.brake_finished   = ($urandom_range(0, 1) == 0);
      cart.reverse_finished = ($urandom_range(0, 3) == 0);
      cart.buzz_finished    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      e = {m_outs(), m_code(), mlat};
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL random c=%0d got %h want %h", c, snap, e);
      end
    end
  endtask

  initial begin
    cart.end_of_track = 0; cart.uturn_finished = 0;
    cart.brake_finished = 0; cart.reverse_finished = 0;
    cart.buzz_finished = 0;
    tick(2);
    test_reset();
    rst = 1'b1;
    tick(2);
    test_delivery();
    test_nocolor();
    test_passes();
    test_priority();
    test_watchdog();
    test_glitch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
